demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 SHALL have parameter DATA_W, default 12, data word width.
REQ-002 SHALL have parameter CNT_W, default 8, width of each delivered-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_data, input, DATA_W, word to route.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port sel, input, 1, destination: 0 = channel A, 1 = channel B; sampled only on an accepted transfer.
REQ-008 SHALL have port in_ready, output, 1, block can accept a word for the channel named by sel.
REQ-009 SHALL have ports out_a_data / out_b_data, output, DATA_W, per-channel data.
REQ-010 SHALL have ports out_a_valid / out_b_valid, output, 1, per-channel data valid.
REQ-011 SHALL have ports out_a_ready / out_b_ready, input, 1, per-channel sink ready.
REQ-012 SHALL have port cnt_clr, input, 1, synchronous clear of both counters.
REQ-013 SHALL have ports cnt_a / cnt_b, output, CNT_W, words delivered per channel.

Function
REQ-014 SHALL treat an input transfer as accepted in any cycle with in_valid=1 and in_ready=1; an output transfer as any cycle with out_x_valid=1 and out_x_ready=1.
REQ-015 SHALL hold one word per channel in a one-entry slot; out_x_valid equals slot-full.
REQ-016 SHALL drive in_ready combinationally = (slot[sel] empty) OR (out_sel_ready=1), so that a drain and refill of the same slot in one cycle are supported.
REQ-017 SHALL load in_data into slot[sel] on acceptance; out_x_valid rises the next cycle (latency 1, no combinational in-to-out path).
REQ-018 SHALL clear slot full on an output transfer with no same-cycle accept into that slot.
REQ-019 SHALL, on simultaneous output transfer and accept into the same slot, keep it full and present the new word next cycle.
REQ-020 SHALL hold out_x_data and out_x_valid stable while out_x_valid=1 and out_x_ready=0.
REQ-021 SHALL leave the non-selected slot unaffected by an accept; both channels may drain in the same cycle.
REQ-022 SHALL permit sel and in_data to change while in_valid=1 without acceptance; in_ready follows the new sel.
REQ-023 SHALL increment cnt_x by 1 on each channel-x output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL zero both counters when cnt_clr=1, overriding a same-cycle increment.
REQ-025 SHALL keep out_x_data at its last value when slot empties (no zeroing).

Reset
REQ-026 SHALL, while rst_n=0, force both slots empty, out_a_valid=out_b_valid=0, out_a_data=out_b_data=0, cnt_a=cnt_b=0.
REQ-027 SHALL discard held words on reset mid-operation; no word is delivered after reset release without a new accept.
REQ-028 SHALL drive in_ready=1 during and after reset (both slots empty).

Structure
REQ-029 SHALL place DATA_W default, CNT_W default and the channel encoding constants (CH_A=0, CH_B=1) in shared package demux_pkg.
REQ-030 SHALL implement each channel as an instance of sub-module demux_slot (one-entry registered slot with valid/ready and delivery counter), instantiated twice.

Verification
REQ-031 SHALL cover: after reset, in_data=0x5A5, sel=0, in_valid 1 cycle, out_a_ready=1 -> out_a_valid high 1 cycle later with 0x5A5, cnt_a=1, out_b_valid stays 0.
REQ-032 SHALL cover: out_b_ready=0, accept 0x123 on B, then offer 0x456 on B -> in_ready=0, out_b_data holds 0x123; raise out_b_ready -> 0x456 accepted same cycle, presented next cycle.
REQ-033 SHALL cover: B full and stalled, offer 0x777 with sel=0 -> accepted, delivered on A; B contents unchanged.
REQ-034 SHALL cover: continuous stream of 300 words to A with out_a_ready=1 -> one word per cycle, no bubbles, cnt_a=44 (wrap at 256).
REQ-035 SHALL cover: cnt_clr=1 in a cycle with an A delivery -> cnt_a=0 next cycle.
REQ-036 SHALL cover: rst_n asserted while both slots full -> valids low immediately, counters 0, no stale word after release.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Purpose  : Shared constants and types for the two-channel demux router.
//  Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

  // Default data word width.
  localparam int DATA_W_DEF = 12;
  // Default delivered-word counter width.
  localparam int CNT_W_DEF  = 8;

  // Channel encoding carried on the sel input.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Occupancy of a one-entry channel slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Counter step with natural modulo-2^w wrap.
  function automatic logic [31:0] cnt_inc(input logic [31:0] cur, input int w);
    logic [31:0] mask;
    mask    = (32'd1 << w) - 32'd1;
    cnt_inc = (cur + 32'd1) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry registered channel slot with valid/ready handshake
//             on the sink side and a wrapping delivered-word counter.
//  Revision : 1.0  initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,        // accepted word targets this slot
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,       // sink ready
  input  logic              i_clr,         // synchronous counter clear
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_can_accept,  // empty, or draining this cycle
  output logic [CNT_W-1:0]  o_cnt
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_xfer;
  logic [31:0]       w_cnt_inc;

  // A word leaves the slot whenever it is held and the sink takes it.
  assign w_xfer       = (r_state == SLOT_FULL) & i_ready;
  // Space exists if empty now, or if the held word leaves on this edge.
  assign o_can_accept = (r_state == SLOT_EMPTY) | i_ready;
  assign o_valid      = (r_state == SLOT_FULL);
  assign o_data       = r_data;
  assign o_cnt        = r_cnt;
  assign w_cnt_inc    = cnt_inc(32'(r_cnt), CNT_W);

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next state: a load always wins so drain+refill stays full.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load) begin
      w_state_nxt = SLOT_FULL;
    end else if (w_xfer) begin
      w_state_nxt = SLOT_EMPTY;
    end
  end

  // Data register only changes on a load, so it holds its last word when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  // Delivered-word counter; clear has priority over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : demux_router
//  Purpose  : Routes a valid/ready input stream to one of two output
//             channels (A/B) chosen by sel, each buffered by a one-entry slot
//             and counting the words it delivers.
//  Revision : 1.0  initial release
// ============================================================================
module demux_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              sel,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [DATA_W-1:0] out_b_data,
  output logic              out_b_valid,
  input  logic              out_b_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  logic w_can_a;
  logic w_can_b;
  logic w_accept;
  logic w_load_a;
  logic w_load_b;

  // Readiness follows the currently selected channel, even before acceptance.
  assign in_ready = (sel == CH_B) ? w_can_b : w_can_a;
  assign w_accept = in_valid & in_ready;
  assign w_load_a = w_accept & (sel == CH_A);
  assign w_load_b = w_accept & (sel == CH_B);

  demux_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load_a),
    .i_data       (in_data),
    .i_ready      (out_a_ready),
    .i_clr        (cnt_clr),
    .o_valid      (out_a_valid),
    .o_data       (out_a_data),
    .o_can_accept (w_can_a),
    .o_cnt        (cnt_a)
  );

  demux_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load_b),
    .i_data       (in_data),
    .i_ready      (out_b_ready),
    .i_clr        (cnt_clr),
    .o_valid      (out_b_valid),
    .o_data       (out_b_data),
    .o_can_accept (w_can_b),
    .o_cnt        (cnt_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_router
//  Purpose  : Self-checking bench for demux_router: directed scenarios plus a
//             randomized run against a behavioural channel model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_router;

  localparam int DW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          sel = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_a_data;
  logic          out_a_valid;
  logic          out_a_ready = 1'b0;
  logic [DW-1:0] out_b_data;
  logic          out_b_valid;
  logic          out_b_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: per channel, is a word waiting, what was last loaded,
  // and how many words have been delivered (modulo 2^CW).
  bit            m_full [2];
  logic [DW-1:0] m_data [2];
  int            m_cnt  [2];

  demux_router #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_clr     (cnt_clr),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    bit rdy;
    rdy = (sel == 1'b1) ? out_b_ready : out_a_ready;
    return !m_full[sel] || rdy;
  endfunction

  task automatic m_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_full[ch] = 1'b0;
      m_data[ch] = '0;
      m_cnt[ch]  = 0;
    end
  endtask

  // Apply inputs half a cycle away from the active edge.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d,
                       input logic ra, input logic rb, input logic clr);
    @(negedge clk);
    in_valid = v; sel = s; in_data = d;
    out_a_ready = ra; out_b_ready = rb; cnt_clr = clr;
    #1;
  endtask

  // Advance the model by the effect of the coming rising edge.
  task automatic commit();
    bit acc;
    bit xf;
    bit rdy [2];
    if (!rst_n) begin
      m_reset();
      return;
    end
    rdy[0] = out_a_ready;
    rdy[1] = out_b_ready;
    acc = in_valid && m_ready();
    for (int ch = 0; ch < 2; ch++) begin
      xf = m_full[ch] && rdy[ch];
      if (cnt_clr)      m_cnt[ch] = 0;
      else if (xf)      m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CW);
      if (acc && (int'(sel) == ch)) begin
        m_full[ch] = 1'b1;
        m_data[ch] = in_data;
      end else if (xf) begin
        m_full[ch] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    m_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({out_b_valid, out_a_valid} !== 2'b00) begin n_err++;
      $display("FAIL reset_valids: got %b want 00", {out_b_valid, out_a_valid}); end
    n_cmp++; if ({out_b_data, out_a_data} !== 24'h0) begin n_err++;
      $display("FAIL reset_data: got %h want 000000", {out_b_data, out_a_data}); end
    n_cmp++; if ({cnt_b, cnt_a} !== 16'h0) begin n_err++;
      $display("FAIL reset_cnts: got %h want 0000", {cnt_b, cnt_a}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready_a: got %b want 1", in_ready); end
    sel = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready_b: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_a();
    drive(1'b1, 1'b0, 12'h5A5, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_a_valid !== 1'b0) begin n_err++;
      $display("FAIL basic_no_comb_path: got %b want 0", out_a_valid); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, out_a_data} !== {1'b1, 12'h5A5}) begin n_err++;
      $display("FAIL basic_a_out: got %b/%h want 1/5a5", out_a_valid, out_a_data); end
    n_cmp++; if (out_b_valid !== 1'b0) begin n_err++;
      $display("FAIL basic_b_quiet: got %b want 0", out_b_valid); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, out_a_data, cnt_a} !== {1'b0, 12'h5A5, 8'd1}) begin n_err++;
      $display("FAIL basic_after: got %b/%h/%0d want 0/5a5/1", out_a_valid, out_a_data, cnt_a); end
    n_cmp++; if (out_b_valid !== 1'b0) begin n_err++;
      $display("FAIL basic_b_still_quiet: got %b want 0", out_b_valid); end
    commit();
  endtask

  task automatic test_stall_b();
    drive(1'b1, 1'b1, 12'h123, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL stall_first_ready: got %b want 1", in_ready); end
    commit();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 12'h456, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++;
        $display("FAIL stall_ready_low: got %b want 0", in_ready); end
      n_cmp++; if ({out_b_valid, out_b_data} !== {1'b1, 12'h123}) begin n_err++;
        $display("FAIL stall_hold: got %b/%h want 1/123", out_b_valid, out_b_data); end
      commit();
    end
    drive(1'b1, 1'b1, 12'h456, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL stall_refill_ready: got %b want 1", in_ready); end
    commit();
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_b_valid, out_b_data, cnt_b} !== {1'b1, 12'h456, 8'd1}) begin n_err++;
      $display("FAIL stall_refill_out: got %b/%h/%0d want 1/456/1", out_b_valid, out_b_data, cnt_b); end
    commit();
  endtask

  task automatic test_cross();
    drive(1'b1, 1'b0, 12'h777, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL cross_ready: got %b want 1", in_ready); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, out_a_data} !== {1'b1, 12'h777}) begin n_err++;
      $display("FAIL cross_a_out: got %b/%h want 1/777", out_a_valid, out_a_data); end
    n_cmp++; if ({out_b_valid, out_b_data} !== {1'b1, 12'h456}) begin n_err++;
      $display("FAIL cross_b_kept: got %b/%h want 1/456", out_b_valid, out_b_data); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({out_a_valid, out_b_valid, cnt_a, cnt_b} !== {2'b00, 8'd2, 8'd2}) begin n_err++;
      $display("FAIL cross_drained: got %b%b/%0d/%0d want 00/2/2", out_a_valid, out_b_valid, cnt_a, cnt_b); end
    commit();
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    commit();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, DW'(i), 1'b1, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if ({out_a_valid, out_a_data} !== {1'b1, DW'(i - 1)}) begin n_err++;
          $display("FAIL stream_word[%0d]: got %b/%h want 1/%h", i, out_a_valid, out_a_data, DW'(i - 1)); end
      end
      commit();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, out_a_data} !== {1'b1, 12'd299}) begin n_err++;
      $display("FAIL stream_last: got %b/%h want 1/12b", out_a_valid, out_a_data); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, cnt_a, cnt_b} !== {1'b0, 8'd44, 8'd0}) begin n_err++;
      $display("FAIL stream_count: got %b/%0d/%0d want 0/44/0", out_a_valid, cnt_a, cnt_b); end
    commit();
  endtask

  task automatic test_clr();
    drive(1'b1, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0);
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({out_a_valid, cnt_a} !== {1'b1, 8'd44}) begin n_err++;
      $display("FAIL clr_before: got %b/%0d want 1/44", out_a_valid, cnt_a); end
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_a_valid, cnt_a} !== {1'b0, 8'd0}) begin n_err++;
      $display("FAIL clr_after: got %b/%0d want 0/0", out_a_valid, cnt_a); end
    commit();
  endtask

  task automatic test_random();
    logic [42:0] got;
    logic [42:0] exp;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom % 2), DW'($urandom),
            ($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0);
      got = {out_b_valid, out_a_valid, out_b_data, out_a_data, cnt_b, cnt_a, in_ready};
      exp = {m_full[1], m_full[0], m_data[1], m_data[0],
             CW'(m_cnt[1]), CW'(m_cnt[0]), m_ready()};
      n_cmp++; if (got !== exp) begin n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, got, exp); end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    commit();
    drive(1'b1, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0);
    commit();
    drive(1'b1, 1'b1, 12'h222, 1'b0, 1'b0, 1'b0);
    commit();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({out_b_valid, out_a_valid} !== 2'b11) begin n_err++;
      $display("FAIL rmid_full: got %b want 11", {out_b_valid, out_a_valid}); end
    commit();
    @(negedge clk); rst_n = 1'b0; #1;
    m_reset();
    n_cmp++; if ({out_b_valid, out_a_valid, cnt_b, cnt_a} !== 18'h0) begin n_err++;
      $display("FAIL rmid_async: got %b%b/%0d/%0d want 00/0/0", out_b_valid, out_a_valid, cnt_b, cnt_a); end
    n_cmp++; if ({out_b_data, out_a_data, in_ready} !== {24'h0, 1'b1}) begin n_err++;
      $display("FAIL rmid_data: got %h/%h/%b want 000/000/1", out_b_data, out_a_data, in_ready); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    commit();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if ({out_b_valid, out_a_valid, cnt_b, cnt_a} !== 18'h0) begin n_err++;
        $display("FAIL rmid_stale[%0d]: got %b%b/%0d/%0d want 00/0/0", k, out_b_valid, out_a_valid, cnt_b, cnt_a); end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_basic_a();
    test_stall_b();
    test_cross();
    test_stream();
    test_clr();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
